alu_reverse_unit: RTL and testbench
===================================

# alu_reverse_unit

Bit-serial operand-recovery unit, the inverse companion of the team's 32-bit reversible ALU. Given an ALU result `F`, the known operand `A`, the select code, `Cin` and the observed `Cout`, it reconstructs operand `B` one bit per cycle, LSB first. It also reports which bits of `B` cannot be determined and whether the supplied result is inconsistent with any `B`. It sits downstream of the ALU in the uncompute / verification path, behind a valid/ready handshake on both sides.

## Interface
- `WIDTH`, default 32: operand width.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request.
- `in_f` input WIDTH: ALU result F.
- `in_a` input WIDTH: known operand A.
- `in_sel` input 2: ALU select code. 00 = AND, 01 = OR, 10 = XOR, 11 = SUM (result is A^B).
- `in_cin` input 1: carry-in applied to the ALU.
- `in_cout` input 1: carry-out reported by the ALU.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_b` output WIDTH: recovered B. Ambiguous bits read 0.
- `out_ambig` output WIDTH: 1 marks a bit of B that is undetermined.
- `out_err` output 1: F is unreachable for the given A and sel.
- `out_cout_chk` output 1: the carry check was performed.
- `out_cout_err` output 1: the carry check failed.

## Operation
- FSM states IDLE, RUN and DONE. Reset forces IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch F, A, sel, cin and cout into shift registers. Clear the B, ambig and err accumulators. Set carry = cin and bit counter = 0. Go to RUN.
- RUN: process bit i = counter, one bit per cycle, from the LSBs of the F and A shift registers.
  - sel 00 (AND):
    - a=1: b=f.
    - a=0: b=0, ambig=1; err |= f.
  - sel 01 (OR):
    - a=0: b=f.
    - a=1: b=0, ambig=1; err |= ~f.
  - sel 1x: b=a^f, ambig=0.
  - Carry chain, every sel: carry ← carry ^ (a & b).
  - Chain validity: a bit with ambig=1 and a=1 makes the chain undetermined. This can only occur for OR. Set the sticky flag `nochk`.
  - Shift b into `out_b` and ambig into `out_ambig` at position i.
  - Leave RUN when counter == WIDTH-1.
- DONE:
  - `out_valid`=1.
  - `out_cout_chk` = ~nochk.
  - `out_cout_err` = ~nochk & (carry != latched cout).
  - All outputs are held stable until `out_ready`=1, then go to IDLE.
- No pipelining: only one request is in flight at a time.
- `in_ready`=0 in RUN and DONE.
- Reset mid-operation:
  - Aborts the request immediately; no partial result is emitted.
  - `out_valid`=0, `in_ready`=1 on the cycle after reset is released.
- Counter width is $clog2(WIDTH). It never wraps in use because it is reset on each accept.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - `out_b`=0, `out_ambig`=0.
  - `out_err`=0, `out_cout_chk`=0, `out_cout_err`=0.
- Accept: handshake at edge N when `in_valid` & `in_ready`. RUN occupies edges N+1..N+WIDTH.
- Result: `out_valid` goes high after edge N+WIDTH, i.e. latency WIDTH+1 cycles. This is 33 for WIDTH=32.
- Release: DONE→IDLE on the edge where `out_valid` & `out_ready`. `in_ready` is high on the following cycle.
- Minimum request spacing is WIDTH+2 cycles.
- `in_valid` is ignored outside IDLE. A source holding `in_valid` sees it accepted only in IDLE.
- Data outputs may change only while `out_valid`=0.

## Structure
- Package `alu_rev_pkg`:
  - Select constants SEL_AND=2'b00, SEL_OR=2'b01, SEL_XOR=2'b10, SEL_SUM=2'b11.
  - FSM state enum (IDLE, RUN, DONE).
- Sub-module `alu_rev_bit`: combinational single-bit recovery.
  - Inputs: a, f, sel, carry_in.
  - Outputs: b, ambig, err, carry_out, nochk.
  - Instantiated once and reused every RUN cycle.
- The top level holds the FSM, counter, shift registers and sticky flags.

## Test plan
- XOR recovery:
  - sel=10, A=0x000000FF, F=0x00000F0F, cin=0, cout=0 → B=0x00000FF0, ambig=0, err=0, cout_chk=1, cout_err=0.
  - Same request with cout=1 → cout_err=1.
- AND recovery:
  - sel=00, A=0xFFFF0000, F=0x12340000 → B=0x12340000, ambig=0x0000FFFF, err=0, cout_chk=1.
  - F=0x00000001 with the same A → err=1.
- OR ambiguity: sel=01, A=0x0000FFFF, F=0xABCDFFFF → B=0xABCD0000, ambig=0x0000FFFF, err=0, cout_chk=0, cout_err=0.
- Latency and backpressure:
  - `in_valid` accepted at edge 0 → `out_valid` high after edge 32.
  - Hold `out_ready`=0 for 10 cycles → outputs stable and `in_ready`=0 throughout.
  - `in_ready`=1 one cycle after release.
- Reset mid-RUN:
  - Assert `rst_n`=0 at RUN bit 5 → `out_valid` never rises and all outputs read 0.
  - The next request (the XOR case above) produces correct results.
- Back-to-back: hold `in_valid`=1 with two queued requests → the second is accepted exactly one cycle after the first result is released, and both results are correct.

Source files
------------

// File: rtl/alu_rev_pkg.sv
// Shared types for the bit-serial operand-recovery unit.
// Select codes and FSM state encoding.
package alu_rev_pkg;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;
    localparam logic [1:0] SEL_SUM = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_reverse_unit_if.sv
// Request/result handshake bundle for alu_reverse_unit.
// The unit is the slave; the producer/consumer side is the master.
interface alu_reverse_unit_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_f;
    logic [WIDTH-1:0] in_a;
    logic [1:0]       in_sel;
    logic             in_cin;
    logic             in_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_ambig;
    logic             out_err;
    logic             out_cout_chk;
    logic             out_cout_err;

    modport master (
        output in_valid,
        input  in_ready,
        output in_f,
        output in_a,
        output in_sel,
        output in_cin,
        output in_cout,
        input  out_valid,
        output out_ready,
        input  out_b,
        input  out_ambig,
        input  out_err,
        input  out_cout_chk,
        input  out_cout_err
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_f,
        input  in_a,
        input  in_sel,
        input  in_cin,
        input  in_cout,
        output out_valid,
        input  out_ready,
        output out_b,
        output out_ambig,
        output out_err,
        output out_cout_chk,
        output out_cout_err
    );

endinterface

// File: rtl/alu_rev_bit.sv
// Single-bit inverse of the reversible ALU slice.
// Recovers b from a and f and advances the carry chain.
import alu_rev_pkg::*;

module alu_rev_bit (
    input  logic       a,
    input  logic       f,
    input  logic [1:0] sel,
    input  logic       carry_in,
    output logic       b,
    output logic       ambig,
    output logic       err,
    output logic       carry_out,
    output logic       nochk
);

    always_comb begin
        b     = 1'b0;
        ambig = 1'b0;
        err   = 1'b0;
        unique case (1'b1)
            (sel == SEL_AND): begin
                if (a) begin
                    b = f;
                end else begin
                    ambig = 1'b1;
                    err   = f;
                end
            end
            (sel == SEL_OR): begin
                if (!a) begin
                    b = f;
                end else begin
                    ambig = 1'b1;
                    err   = ~f;
                end
            end
            (sel == SEL_XOR),
            (sel == SEL_SUM): begin
                b = a ^ f;
            end
            default: begin
                b = 1'b0;
            end
        endcase
    end

    // an unknown b under a=1 leaves the carry contribution unknown
    assign nochk     = ambig & a;
    assign carry_out = carry_in ^ (a & b);

endmodule

// File: rtl/alu_reverse_unit.sv
// Bit-serial recovery of operand B from an ALU result, LSB first.
// One request in flight; results held until the consumer accepts.
import alu_rev_pkg::*;

module alu_reverse_unit #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    alu_reverse_unit_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] f_sh;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] am_q;
    logic [1:0]       sel_q;
    logic             carry;
    logic             cout_q;
    logic             err_q;
    logic             nochk_q;
    logic             rdy_q;
    logic             vld_q;
    logic             chk_q;
    logic             cerr_q;

    logic b_bit;
    logic am_bit;
    logic err_bit;
    logic c_nxt;
    logic nochk_bit;
    logic nochk_nxt;

    alu_rev_bit u_bit (
        .a         (a_sh[0]),
        .f         (f_sh[0]),
        .sel       (sel_q),
        .carry_in  (carry),
        .b         (b_bit),
        .ambig     (am_bit),
        .err       (err_bit),
        .carry_out (c_nxt),
        .nochk     (nochk_bit)
    );

    assign nochk_nxt = nochk_q | nochk_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            f_sh    <= '0;
            a_sh    <= '0;
            b_q     <= '0;
            am_q    <= '0;
            sel_q   <= SEL_AND;
            carry   <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            nochk_q <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            chk_q   <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        f_sh    <= bus.in_f;
                        a_sh    <= bus.in_a;
                        sel_q   <= bus.in_sel;
                        carry   <= bus.in_cin;
                        cout_q  <= bus.in_cout;
                        cnt     <= '0;
                        b_q     <= '0;
                        am_q    <= '0;
                        err_q   <= 1'b0;
                        nochk_q <= 1'b0;
                        chk_q   <= 1'b0;
                        cerr_q  <= 1'b0;
                        rdy_q   <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // new bits enter at the MSB; after WIDTH shifts bit i sits at i
                    b_q     <= {b_bit, b_q[WIDTH-1:1]};
                    am_q    <= {am_bit, am_q[WIDTH-1:1]};
                    f_sh    <= f_sh >> 1;
                    a_sh    <= a_sh >> 1;
                    err_q   <= err_q | err_bit;
                    nochk_q <= nochk_nxt;
                    carry   <= c_nxt;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        chk_q  <= ~nochk_nxt;
                        cerr_q <= ~nochk_nxt & (c_nxt != cout_q);
                        vld_q  <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        vld_q <= 1'b0;
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = rdy_q;
    assign bus.out_valid    = vld_q;
    assign bus.out_b        = b_q;
    assign bus.out_ambig    = am_q;
    assign bus.out_err      = err_q;
    assign bus.out_cout_chk = chk_q;
    assign bus.out_cout_err = cerr_q;

endmodule

// File: tb/tb_alu_reverse_unit.sv
// Directed and randomized bench for alu_reverse_unit.
// Expected results come from a word-level model of the recovery rules.
module tb_alu_reverse_unit;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_reverse_unit_if #(.WIDTH(W)) bus ();

    alu_reverse_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(
        input  logic [W-1:0] f,
        input  logic [W-1:0] a,
        input  logic [1:0]   sel,
        input  logic         cin,
        input  logic         cout,
        output logic [W-1:0] b,
        output logic [W-1:0] am,
        output logic         e,
        output logic         chk,
        output logic         cerr
    );
        logic nochk;
        logic carry;
        case (sel)
            2'b00: begin
                b  = f & a;
                am = ~a;
                e  = |(f & ~a);
            end
            2'b01: begin
                b  = f & ~a;
                am = a;
                e  = |(~f & a);
            end
            default: begin
                b  = a ^ f;
                am = '0;
                e  = 1'b0;
            end
        endcase
        nochk = |(am & a);
        carry = cin ^ (^(a & b));
        chk   = ~nochk;
        cerr  = ~nochk & (carry != cout);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] f,
                             input logic [W-1:0] a, input logic [1:0] sel,
                             input logic cin, input logic cout);
        logic [W-1:0] eb;
        logic [W-1:0] ea;
        logic ee;
        logic ec;
        logic ecr;
        model(f, a, sel, cin, cout, eb, ea, ee, ec, ecr);
        check({tag, ".b"}, 64'(bus.out_b), 64'(eb));
        check({tag, ".ambig"}, 64'(bus.out_ambig), 64'(ea));
        check({tag, ".err"}, 64'(bus.out_err), 64'(ee));
        check({tag, ".chk"}, 64'(bus.out_cout_chk), 64'(ec));
        check({tag, ".cerr"}, 64'(bus.out_cout_err), 64'(ecr));
    endtask

    task automatic wait_result(input string tag);
        int k;
        k = 0;
        while (!bus.out_valid && k < W + 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, ".latency"}, 64'(k), 64'(W));
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".vld_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".rdy_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic do_req(input string tag, input logic [W-1:0] f,
                          input logic [W-1:0] a, input logic [1:0] sel,
                          input logic cin, input logic cout,
                          input int hold);
        int t;
        logic [W-1:0] b0;
        logic [W-1:0] am0;
        @(negedge clk);
        t = 0;
        while (!bus.in_ready && t < 2 * W) begin
            @(negedge clk);
            t++;
        end
        check({tag, ".idle"}, 64'(bus.in_ready), 64'd1);
        bus.in_f     = f;
        bus.in_a     = a;
        bus.in_sel   = sel;
        bus.in_cin   = cin;
        bus.in_cout  = cout;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, ".busy"}, 64'(bus.in_ready), 64'd0);
        wait_result(tag);
        check_res(tag, f, a, sel, cin, cout);
        b0  = bus.out_b;
        am0 = bus.out_ambig;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_b"}, 64'(bus.out_b), 64'(b0));
            check({tag, ".hold_am"}, 64'(bus.out_ambig), 64'(am0));
            check({tag, ".hold_vld"}, 64'(bus.out_valid), 64'd1);
            check({tag, ".hold_rdy"}, 64'(bus.in_ready), 64'd0);
        end
        if (hold > 0) check_res({tag, ".held"}, f, a, sel, cin, cout);
        release_result(tag);
    endtask

    initial begin
        logic [W-1:0] rf;
        logic [W-1:0] ra;
        logic [1:0]   rs;
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_f      = '0;
        bus.in_a      = '0;
        bus.in_sel    = 2'b00;
        bus.in_cin    = 1'b0;
        bus.in_cout   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.rdy", 64'(bus.in_ready), 64'd1);
        check("rst.vld", 64'(bus.out_valid), 64'd0);
        check("rst.b", 64'(bus.out_b), 64'd0);
        check("rst.ambig", 64'(bus.out_ambig), 64'd0);
        check("rst.err", 64'(bus.out_err), 64'd0);
        check("rst.chk", 64'(bus.out_cout_chk), 64'd0);
        check("rst.cerr", 64'(bus.out_cout_err), 64'd0);

        do_req("xor0", 32'h00000F0F, 32'h000000FF, 2'b10, 1'b0, 1'b0, 0);
        do_req("xor1", 32'h00000F0F, 32'h000000FF, 2'b10, 1'b0, 1'b1, 0);
        do_req("and0", 32'h12340000, 32'hFFFF0000, 2'b00, 1'b0, 1'b1, 10);
        do_req("and1", 32'h00000001, 32'hFFFF0000, 2'b00, 1'b0, 1'b0, 0);
        do_req("or0", 32'hABCDFFFF, 32'h0000FFFF, 2'b01, 1'b0, 1'b0, 2);

        // abort in the middle of RUN
        @(negedge clk);
        bus.in_f     = 32'h00000F0F;
        bus.in_a     = 32'h000000FF;
        bus.in_sel   = 2'b10;
        bus.in_cin   = 1'b0;
        bus.in_cout  = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort.rdy", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < W + 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0 || i == W + 4)
                check("abort.vld", 64'(bus.out_valid), 64'd0);
        end
        check("abort.b", 64'(bus.out_b), 64'd0);
        check("abort.ambig", 64'(bus.out_ambig), 64'd0);
        check("abort.err", 64'(bus.out_err), 64'd0);
        check("abort.chk", 64'(bus.out_cout_chk), 64'd0);
        check("abort.cerr", 64'(bus.out_cout_err), 64'd0);
        do_req("xor2", 32'h00000F0F, 32'h000000FF, 2'b10, 1'b0, 1'b0, 0);

        // back-to-back with in_valid held high
        @(negedge clk);
        bus.in_f     = 32'h12340000;
        bus.in_a     = 32'hFFFF0000;
        bus.in_sel   = 2'b00;
        bus.in_cin   = 1'b1;
        bus.in_cout  = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b.acc1", 64'(bus.in_ready), 64'd0);
        bus.in_f    = 32'hABCDFFFF;
        bus.in_a    = 32'h0000FFFF;
        bus.in_sel  = 2'b01;
        bus.in_cin  = 1'b0;
        bus.in_cout = 1'b1;
        wait_result("b2b1");
        check_res("b2b1", 32'h12340000, 32'hFFFF0000, 2'b00, 1'b1, 1'b0);
        release_result("b2b1");
        @(posedge clk);
        #1;
        check("b2b.acc2", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        wait_result("b2b2");
        check_res("b2b2", 32'hABCDFFFF, 32'h0000FFFF, 2'b01, 1'b0, 1'b1);
        release_result("b2b2");

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rs = 2'($urandom_range(0, 3));
            rf = $urandom;
            if (rs == 2'b00 && $urandom_range(0, 1) == 0) rf = rf & ra;
            if (rs == 2'b01 && $urandom_range(0, 1) == 0) rf = rf | ra;
            if (rs == 2'b01 && n % 5 == 0) ra = '0;
            do_req("rand", rf, ra, rs, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
